// File: rtl/fetch_stage_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fetch_stage_pkg : shared constants and next-PC selection for the fetch stage
// Rev 1.0
// ============================================================================
package fetch_stage_pkg;

  localparam int          DEFAULT_XLEN     = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_2000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_HOLD   = 2'd3
  } npc_sel_e;

  // Stall dominates; a redirect seen during a stall is dropped and must be re-issued.
  function automatic npc_sel_e npc_select(input logic stall, input logic br, input logic jmp);
    if (stall)    return NPC_HOLD;
    else if (br)  return NPC_BRANCH;
    else if (jmp) return NPC_JUMP;
    else          return NPC_SEQ;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fetch_hold_buf : captures the decode instruction on stall entry, drives instD
// Rev 1.0
// ============================================================================
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        vld,
  input  logic [31:0] imem_dout,
  output logic [31:0] inst
);

  logic [31:0] hold;
  logic        hold_vld;

  // IMEM keeps reading during a stall, so its output moves on to the next
  // word; the word in decode is saved on the first stalled cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= 32'h0;
      hold_vld <= 1'b0;
    end else if (stall) begin
      if (!hold_vld) begin
        hold     <= imem_dout;
        hold_vld <= 1'b1;
      end
    end else begin
      hold_vld <= 1'b0;
    end
  end

  always_comb begin
    inst = imem_dout;
    if (!vld)
      inst = INSTR_NOP;
    else if (hold_vld)
      inst = hold;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fetch_stage : PC register, next-PC/redirect logic and IMEM interface
// Rev 1.0
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int               XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            PCSel_bit1,
  input  logic [XLEN-1:0] BTarg,
  input  logic            jump,
  input  logic [XLEN-1:0] JTarg,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_en,
  input  logic [31:0]     imem_dout,
  output logic [31:0]     instD,
  output logic [XLEN-1:0] pc_plus4D,
  output logic            validD
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pc_d;
  logic            vld;
  logic [XLEN-1:0] next_pc;
  logic            redirect;
  npc_sel_e        sel;

  assign sel      = npc_select(stall, PCSel_bit1, jump);
  assign redirect = (sel == NPC_BRANCH) || (sel == NPC_JUMP);

  always_comb begin
    next_pc = pc_f + XLEN'(4);
    case (sel)
      NPC_HOLD:   next_pc = pc_f;
      NPC_BRANCH: next_pc = BTarg & ALIGN_MASK;
      NPC_JUMP:   next_pc = JTarg & ALIGN_MASK;
      default:    next_pc = pc_f + XLEN'(4);
    endcase
  end

  // The word fetched in a redirect cycle is on the wrong path; it enters decode invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f <= RESET_PC;
      pc_d <= RESET_PC;
      vld  <= 1'b0;
    end else begin
      pc_f <= next_pc;
      if (!stall) begin
        pc_d <= pc_f;
        vld  <= !redirect;
      end
    end
  end

  fetch_hold_buf u_hold (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .vld       (vld),
    .imem_dout (imem_dout),
    .inst      (instD)
  );

  assign imem_addr = pc_f;
  assign imem_en   = !rst;
  assign pc_plus4D = pc_d + XLEN'(4);
  assign validD    = vld;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fetch_stage : self-checking bench for fetch_stage with IMEM and reference model
// Rev 1.0
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] RPC  = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        PCSel_bit1 = 1'b0;
  logic [31:0] BTarg = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] JTarg = 32'h0;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_dout = 32'h0;
  logic [31:0] instD;
  logic [31:0] pc_plus4D;
  logic        validD;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];

  // Reference model: fetch address, decode address, decode-valid.
  logic [31:0] m_pcF, m_pcD;
  logic        m_vld;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .PCSel_bit1 (PCSel_bit1),
    .BTarg      (BTarg),
    .jump       (jump),
    .JTarg      (JTarg),
    .imem_addr  (imem_addr),
    .imem_en    (imem_en),
    .imem_dout  (imem_dout),
    .instD      (instD),
    .pc_plus4D  (pc_plus4D),
    .validD     (validD)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_dout <= mem[imem_addr[11:2]];

  function automatic logic [31:0] memw(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  function automatic logic [31:0] exp_inst();
    return m_vld ? memw(m_pcD) : NOP;
  endfunction

  task automatic model_reset();
    m_pcF = RPC;
    m_pcD = RPC;
    m_vld = 1'b0;
  endtask

  // Drive one cycle of decode-side inputs, advance model and DUT by one edge.
  task automatic step(input logic s, input logic b, input logic j,
                      input logic [31:0] bt, input logic [31:0] jt);
    logic        redir;
    logic [31:0] tgt;
    stall = s; PCSel_bit1 = b; jump = j; BTarg = bt; JTarg = jt;
    redir = !s && (b || j);
    tgt   = (b ? bt : jt) & 32'hFFFF_FFFC;
    @(posedge clk);
    if (!s) begin
      m_pcD = m_pcF;
      m_vld = !redir;
      m_pcF = redir ? tgt : m_pcF + 32'd4;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    mem[RPC[11:2]] = 32'h0050_0093;
    @(posedge clk); #1;
    checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", imem_en); end
    checks++; if (imem_addr !== RPC) begin errors++; $display("FAIL rst_addr got %h exp %h", imem_addr, RPC); end
    checks++; if (pc_plus4D !== 32'h2004) begin errors++; $display("FAIL rst_pc4 got %h exp 2004", pc_plus4D); end
    checks++; if (instD !== NOP) begin errors++; $display("FAIL rst_inst got %h exp %h", instD, NOP); end
    rst = 1'b0;
    #1;
    checks++; if (validD !== 1'b0) begin errors++; $display("FAIL cyc0_valid got %b exp 0", validD); end
    checks++; if (imem_en !== 1'b1) begin errors++; $display("FAIL cyc0_en got %b exp 1", imem_en); end
    step(0, 0, 0, 0, 0);
    checks++; if (instD !== 32'h0050_0093) begin errors++; $display("FAIL cyc1_inst got %h exp 00500093", instD); end
    checks++; if (pc_plus4D !== 32'h2004) begin errors++; $display("FAIL cyc1_pc4 got %h exp 2004", pc_plus4D); end
    checks++; if (validD !== 1'b1) begin errors++; $display("FAIL cyc1_valid got %b exp 1", validD); end
    step(0, 0, 0, 0, 0);
    checks++; if (imem_addr !== 32'h2008) begin errors++; $display("FAIL cyc2_addr got %h exp 2008", imem_addr); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      checks++; if (pc_plus4D !== 32'h2008 + 32'(4 * i)) begin errors++; $display("FAIL seq_pc4 got %h exp %h", pc_plus4D, 32'h2008 + 32'(4 * i)); end
      checks++; if (validD !== 1'b1) begin errors++; $display("FAIL seq_valid got %b exp 1", validD); end
      checks++; if (instD !== memw(32'h2004 + 32'(4 * i))) begin errors++; $display("FAIL seq_inst got %h exp %h", instD, memw(32'h2004 + 32'(4 * i))); end
      step(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_branch();
    step(0, 1, 0, 32'h2100, 32'h5555_5550);
    checks++; if (imem_addr !== 32'h2100) begin errors++; $display("FAIL br_addr got %h exp 2100", imem_addr); end
    checks++; if (validD !== 1'b0) begin errors++; $display("FAIL br_bubble_valid got %b exp 0", validD); end
    checks++; if (instD !== NOP) begin errors++; $display("FAIL br_bubble_inst got %h exp %h", instD, NOP); end
    step(0, 0, 0, 0, 0);
    checks++; if (pc_plus4D !== 32'h2104) begin errors++; $display("FAIL br_pc4 got %h exp 2104", pc_plus4D); end
    checks++; if (validD !== 1'b1) begin errors++; $display("FAIL br_valid got %b exp 1", validD); end
    checks++; if (instD !== memw(32'h2100)) begin errors++; $display("FAIL br_inst got %h exp %h", instD, memw(32'h2100)); end
  endtask

  task automatic test_stall();
    mem[32'h2200 >> 2 & 32'h3FF] = 32'h00A0_0113;
    mem[32'h2204 >> 2 & 32'h3FF] = 32'h00B0_0193;
    step(0, 0, 1, 0, 32'h2200);
    step(0, 0, 0, 0, 0);
    checks++; if (instD !== 32'h00A0_0113) begin errors++; $display("FAIL stall_pre_inst got %h exp 00a00113", instD); end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      checks++; if (instD !== 32'h00A0_0113) begin errors++; $display("FAIL stall_inst got %h exp 00a00113", instD); end
      checks++; if (pc_plus4D !== 32'h2204) begin errors++; $display("FAIL stall_pc4 got %h exp 2204", pc_plus4D); end
      checks++; if (imem_addr !== 32'h2204) begin errors++; $display("FAIL stall_addr got %h exp 2204", imem_addr); end
      checks++; if (validD !== 1'b1) begin errors++; $display("FAIL stall_valid got %b exp 1", validD); end
    end
    step(0, 0, 0, 0, 0);
    checks++; if (instD !== 32'h00B0_0193) begin errors++; $display("FAIL stall_next_inst got %h exp 00b00193", instD); end
    checks++; if (pc_plus4D !== 32'h2208) begin errors++; $display("FAIL stall_next_pc4 got %h exp 2208", pc_plus4D); end
  endtask

  task automatic test_stall_jump();
    logic [31:0] a0;
    a0 = imem_addr;
    step(1, 0, 1, 0, 32'h3000);
    checks++; if (imem_addr !== a0) begin errors++; $display("FAIL stj_addr got %h exp %h", imem_addr, a0); end
    step(0, 0, 1, 0, 32'h3000);
    checks++; if (imem_addr !== 32'h3000) begin errors++; $display("FAIL stj_redirect got %h exp 3000", imem_addr); end
    checks++; if (validD !== 1'b0) begin errors++; $display("FAIL stj_bubble got %b exp 0", validD); end
  endtask

  task automatic test_wrap();
    step(0, 0, 1, 0, 32'hFFFF_FFFF);
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align got %h exp fffffffc", imem_addr); end
    step(0, 0, 0, 0, 0);
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", imem_addr); end
    checks++; if (pc_plus4D !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h exp 0", pc_plus4D); end
    checks++; if (instD !== mem[1023]) begin errors++; $display("FAIL wrap_inst got %h exp %h", instD, mem[1023]); end
  endtask

  task automatic test_random(input int n);
    logic        s, b, j;
    logic [31:0] bt, jt;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (imem_addr !== m_pcF || pc_plus4D !== m_pcD + 32'd4 || validD !== m_vld || instD !== exp_inst()) begin
        errors++;
        $display("FAIL rand cyc %0d got addr=%h pc4=%h v=%b inst=%h exp addr=%h pc4=%h v=%b inst=%h",
                 i, imem_addr, pc_plus4D, validD, instD, m_pcF, m_pcD + 32'd4, m_vld, exp_inst());
      end
      s  = ($urandom_range(0, 99) < 30);
      b  = ($urandom_range(0, 99) < 10);
      j  = ($urandom_range(0, 99) < 10);
      bt = 32'h2000 + ($urandom & 32'h0000_0FFF);
      jt = 32'h2000 + ($urandom & 32'h0000_0FFF);
      step(s, b, j, bt, jt);
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    checks++; if (dut.u_hold.hold_vld !== 1'b1) begin errors++; $display("FAIL arst_pre_hold got %b exp 1", dut.u_hold.hold_vld); end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (imem_addr !== RPC) begin errors++; $display("FAIL arst_addr got %h exp %h", imem_addr, RPC); end
    checks++; if (validD !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", validD); end
    checks++; if (instD !== NOP) begin errors++; $display("FAIL arst_inst got %h exp %h", instD, NOP); end
    checks++; if (dut.u_hold.hold_vld !== 1'b0) begin errors++; $display("FAIL arst_hold got %b exp 0", dut.u_hold.hold_vld); end
    checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL arst_en got %b exp 0", imem_en); end
    stall = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    step(0, 0, 0, 0, 0);
    checks++; if (instD !== memw(RPC) || validD !== 1'b1) begin errors++; $display("FAIL arst_restart got %h/%b exp %h/1", instD, validD, memw(RPC)); end
    test_random(40);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_stall_jump();
    test_wrap();
    test_random(400);
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
